pipe_reg: RTL and testbench

//  Parametrised multi-stage register pipeline: the successor of the single d_ff.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_reg_if.sv | 32 +++
 rtl/pipe_stage.sv | 38 +++
 rtl/pipe_reg.sv | 82 ++++++++
 tb/tb_pipe_reg.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_reg register pipeline and anything sized from it.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package pipe_pkg;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// Producer/consumer bundle for pipe_reg: input handshake, output handshake, flush, occupancy.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs carried as plain signals.
// Modports: slave = pipeline side (pipe_reg), master = the block driving and draining it.
interface pipe_reg_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    import pipe_pkg::*;

    localparam int OW = occ_width(DEPTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OW-1:0]    occupancy;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus a data register, loaded from upstream when told to advance.
// Latency: 1 cycle from load to valid/data.
// Backpressure: none locally; caller withholds load to stall. clear drops valid, keeps data.
// Ports: clk/rst, load (advance), clear (flush), vin/din (upstream), valid/data (this slot).
module pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                // Loading an empty upstream slot is how a bubble moves forward.
                valid <= vin;
            end
            // Only real words are captured, so flush leaves data untouched and
            // a stalled slot (load=0) can never be overwritten.
            if (load && vin && !clear) begin
                data <= din;
            end
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// DEPTH-stage retiming pipeline with per-stage valid, bubble collapsing and sync flush.
// Latency: DEPTH cycles input->output when unstalled; 1 word/cycle throughput.
// Backpressure: in_ready = advance chain from out_ready (comb, DEPTH deep) gated by ~flush.
// Ports: clk, rst (sync, active-high), pif (slave: flush, in_*, out_*, occupancy).
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    pipe_reg_if.slave  pif
);

    localparam int            OW  = occ_width(DEPTH);
    localparam logic [OW-1:0] ONE = OW'(1);

    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            up_vld;
    logic [DEPTH-1:0][WIDTH-1:0] up_dat;
    logic [DEPTH-1:0][WIDTH-1:0] stage_data;
    logic [OW-1:0]               occ;
    logic                        in_xfer;
    logic                        out_xfer;

    // Stage 0 is the input side, stage DEPTH-1 drives the output.
    assign pif.in_ready  = adv[0] & ~pif.flush;
    assign pif.out_valid = valid[DEPTH-1];
    assign pif.out_data  = stage_data[DEPTH-1];
    assign pif.occupancy = occ;

    assign in_xfer  = pif.in_valid & pif.in_ready;
    assign out_xfer = pif.out_valid & pif.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // A stage may advance when the consumer takes a word or any slot from
        // here to the output is empty. This is the unrolled form of the
        // recursive adv[i] = adv[i+1] | ~valid[i], written without feedback
        // through the adv vector.
        assign adv[i] = pif.out_ready | ~(&valid[DEPTH-1:i]);

        if (i == 0) begin : g_head
            assign up_vld[i] = in_xfer;
            assign up_dat[i] = pif.in_data;
        end else begin : g_body
            assign up_vld[i] = valid[i-1];
            assign up_dat[i] = stage_data[i-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (adv[i]),
            .clear (pif.flush),
            .vin   (up_vld[i]),
            .din   (up_dat[i]),
            .valid (valid[i]),
            .data  (stage_data[i])
        );
    end

    // Occupancy tracks the number of valid stages; a flush-cycle output
    // transfer is absorbed by the clear to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (pif.flush) begin
            occ <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ <= occ + ONE;
        end else if (out_xfer && !in_xfer) begin
            occ <= occ - ONE;
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
// Reference: a queue of in-flight words, each tagged with its slot position.
// Words slide toward the output unless blocked by the word ahead.
module tb_pipe_reg;
    import pipe_pkg::*;

    localparam int          W  = 8;
    localparam int          D  = 3;
    localparam logic [W-1:0] RV = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_reg_if #(.WIDTH(W), .DEPTH(D)) mif ();

    pipe_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .pif (mif.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit known = 1'b0;
    bit lat_chk = 1'b0;

    // Reference model state: oldest word first.
    int           pos_q[$];
    logic [W-1:0] dat_q[$];
    int           acc_q[$];
    int           np_q[$];

    // Values observed at the most recent mid-cycle sample point.
    logic         last_ir, last_ov;
    logic [W-1:0] last_od;
    logic [31:0]  last_occ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next-cycle positions of the surviving words (front word removed if it leaves).
    function automatic void plan(input bit ox);
        int lim;
        int p;
        np_q.delete();
        lim = D - 1;
        for (int k = (ox ? 1 : 0); k < pos_q.size(); k++) begin
            p = pos_q[k] + 1;
            if (p > lim) p = lim;
            np_q.push_back(p);
            lim = p - 1;
        end
    endfunction

    task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                         input bit fl, input bit r, output bit acc);
        bit ov_m, ir_m, ox, ix;
        @(negedge clk);
        rst           = r;
        mif.flush     = fl;
        mif.in_valid  = iv;
        mif.in_data   = id;
        mif.out_ready = ordy;
        #1;
        ov_m = (pos_q.size() > 0) && (pos_q[0] == D - 1);
        ox   = ov_m && ordy;
        plan(ox);
        ir_m = !fl && (np_q.size() == 0 || np_q[np_q.size()-1] > 0);
        ix   = iv && ir_m && !r;
        last_ir  = mif.in_ready;
        last_ov  = mif.out_valid;
        last_od  = mif.out_data;
        last_occ = 32'(mif.occupancy);
        if (known) begin
            chk("out_valid", 32'(mif.out_valid), 32'(ov_m));
            chk("in_ready", 32'(mif.in_ready), 32'(ir_m));
            chk("occupancy", 32'(mif.occupancy), 32'(pos_q.size()));
            if (ov_m) chk("out_data", 32'(mif.out_data), 32'(dat_q[0]));
            if (ox && lat_chk) chk("latency", 32'(cyc - acc_q[0]), 32'(D));
        end
        acc = ix;
        @(posedge clk);
        if (r) begin
            pos_q.delete(); dat_q.delete(); acc_q.delete();
            known = 1'b1;
        end else if (known) begin
            if (ox) begin
                void'(dat_q.pop_front());
                void'(acc_q.pop_front());
            end
            pos_q = np_q;
            if (ix) begin
                pos_q.push_back(0);
                dat_q.push_back(id);
                acc_q.push_back(cyc);
            end
            if (fl) begin
                pos_q.delete(); dat_q.delete(); acc_q.delete();
            end
        end
        cyc++;
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 20 && pos_q.size() > 0; k++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        #2;
        chk("drain_empty", 32'(mif.occupancy), 32'd0);
    endtask

    initial begin
        bit a;
        bit iv, ordy, fl, r;
        mif.flush     = 1'b0;
        mif.in_valid  = 1'b0;
        mif.in_data   = '0;
        mif.out_ready = 1'b0;

        // 1: reset for two cycles
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        #2;
        for (int i = 0; i < D; i++) chk("t1_reset_data", 32'(dut.stage_data[i]), 32'(RV));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
        chk("t1_out_valid", 32'(last_ov), 32'd0);
        chk("t1_occupancy", last_occ, 32'd0);
        chk("t1_in_ready", 32'(last_ir), 32'd1);

        // 2: unstalled stream, latency DEPTH and back-to-back output
        lat_chk = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            cycle(1'b1, W'(v), 1'b1, 1'b0, 1'b0, a);
            chk("t2_accept", 32'(a), 32'd1);
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        lat_chk = 1'b0;
        drain();

        // 3: fill while stalled, 4th refused, then released
        for (int v = 8'h10; v <= 8'h12; v++) begin
            cycle(1'b1, W'(v), 1'b0, 1'b0, 1'b0, a);
            chk("t3_accept", 32'(a), 32'd1);
        end
        cycle(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, a);
        chk("t3_full_refused", 32'(a), 32'd0);
        chk("t3_full_in_ready", 32'(last_ir), 32'd0);
        chk("t3_full_occ", last_occ, 32'd3);
        a = 1'b0;
        for (int k = 0; k < 10 && !a; k++) cycle(1'b1, 8'h13, 1'b1, 1'b0, 1'b0, a);
        chk("t3_accept_13", 32'(a), 32'd1);
        drain();

        // 4: bubble collapse while stalled
        cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, '0,    1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, '0,    1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, '0,    1'b0, 1'b0, 1'b0, a);
        #2;
        chk("t4_occ", 32'(mif.occupancy), 32'd2);
        chk("t4_out_data", 32'(mif.out_data), 32'h20);
        chk("t4_next_stage", 32'(dut.stage_data[D-2]), 32'h21);
        drain();

        // 5: full pipeline flushed while the head transfers out
        cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, a);
        chk("t5_flush_in_ready", 32'(last_ir), 32'd0);
        chk("t5_flush_out_data", 32'(last_od), 32'h30);
        chk("t5_flush_refused", 32'(a), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        chk("t5_after_out_valid", 32'(last_ov), 32'd0);
        chk("t5_after_occ", last_occ, 32'd0);

        // 6: reset overrides flush and input mid-stream
        cycle(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 8'h42, 1'b0, 1'b1, 1'b1, a);
        chk("t6_pre_occ", last_occ, 32'd2);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        chk("t6_occ", last_occ, 32'd0);
        chk("t6_out_valid", 32'(last_ov), 32'd0);

        // Random valid/ready/flush/reset traffic against the reference queue
        for (int k = 0; k < 600; k++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 31) == 0);
            r    = ($urandom_range(0, 127) == 0);
            cycle(iv, W'($urandom), ordy, fl, r, a);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
